// File: rtl/nanov_spi_ram.sv
// Bit-serial SPI RAM model for the nanoV core: READ (0x03) / WRITE (0x02) with
// 24-bit address, little-endian LSB-first data, zero dummy cycles, backdoor load.
module nanov_spi_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_select,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

  state_t               state;
  logic [4:0]           cnt;
  logic [6:0]           cmd_sr;
  logic [6:0]           wr_sr;
  logic [ADDR_BITS-1:0] addr;
  logic                 armed;
  logic [7:0]           mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] addr_full, rd_addr;
  logic [7:0]           cmd_full, rd_byte, wr_byte;
  logic [2:0]           rd_bit;
  logic                 rd_val, wr_commit;

  assign addr_full = {addr[ADDR_BITS-2:0], spi_mosi};
  assign cmd_full  = {cmd_sr, spi_mosi};
  // On the last address edge the read must see the bit arriving right now.
  assign rd_addr   = (state == ADDR) ? addr_full : addr;
  assign rd_bit    = (state == ADDR) ? 3'd0 : cnt[2:0];
  assign rd_byte   = mem[rd_addr];
  assign rd_val    = rd_byte[rd_bit];
  assign wr_byte   = {spi_mosi, wr_sr};
  assign wr_commit = (state == WRITE) && !spi_select && (cnt[2:0] == 3'd7);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd_sr   <= '0;
      wr_sr    <= '0;
      addr     <= '0;
      armed    <= 1'b0;
      spi_miso <= 1'b0;
    end else if (spi_select) begin
      state    <= IDLE;
      cnt      <= '0;
      armed    <= 1'b1;
      spi_miso <= 1'b0;
    end else begin
      spi_miso <= 1'b0;
      case (state)
        IDLE: if (armed) begin
          cmd_sr <= {6'd0, spi_mosi};
          cnt    <= 5'd1;
          state  <= CMD;
        end
        CMD: begin
          cmd_sr <= cmd_full[6:0];
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd7)
            state <= (cmd_full == 8'h03 || cmd_full == 8'h02) ? ADDR : IGNORE;
        end
        ADDR: begin
          addr <= addr_full;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            // cmd_sr[0] is the only bit distinguishing READ from WRITE
            if (cmd_sr[0]) begin
              state    <= READ;
              spi_miso <= rd_val;
              cnt      <= 5'd1;
            end else begin
              state <= WRITE;
              cnt   <= 5'd0;
            end
          end
        end
        READ: begin
          spi_miso <= rd_val;
          cnt      <= {2'b00, cnt[2:0] + 3'd1};
          if (cnt[2:0] == 3'd7) addr <= addr + ADDR_BITS'(1);
        end
        WRITE: begin
          wr_sr <= {spi_mosi, wr_sr[6:1]};
          cnt   <= {2'b00, cnt[2:0] + 3'd1};
          if (wr_commit) addr <= addr + ADDR_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Backdoor load is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr] <= wr_byte;
    if (load_en)   mem[load_addr] <= load_data;
  end
endmodule

// File: doc/nanov_spi_ram.md
# nanov_spi_ram

Single-clock, bit-serial SPI RAM model that sits directly downstream of the nanoV CPU's SPI pins. It is the memory the core streams instructions and data from. It decodes the 8-bit command and the 24-bit address shifted out by the CPU, then either streams bytes back or absorbs written bytes. It supports READ (0x03) and WRITE (0x02) with auto-incrementing addresses. A backdoor load port lets the bench or boot logic preload program images.

## Interface
- ADDR_BITS, 10, implemented address width; memory is 2^ADDR_BITS bytes.
- clk  in  1  system clock; doubles as SPI clock, with all SPI sampling on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- spi_select  in  1  chip select, active low.
- spi_mosi  in  1  serial data from the CPU (the CPU's spi_out).
- spi_miso  out  1  serial data to the CPU (the CPU's spi_data_in); registered.
- load_en  in  1  backdoor byte write strobe.
- load_addr  in  ADDR_BITS  backdoor byte address.
- load_data  in  8  backdoor byte value.

## Operation
- States: IDLE, CMD, ADDR, READ, WRITE, IGNORE. State, bit counter, address and shift registers are reset by rstn. Memory contents are not reset.
- IDLE: on a rising edge with spi_select=0, sample spi_mosi as command bit 7 (MSB first) and go to CMD.
- CMD: shift 7 more bits, so the last command bit lands on select-low edge 8.
  - Go to ADDR if the command is 0x03 or 0x02.
  - Otherwise go to IGNORE.
- ADDR: shift 24 address bits, MSB first, on select-low edges 9..32.
  - Only the low ADDR_BITS bits are kept; upper bits are ignored.
  - Edge 32 enters READ or WRITE using the complete address, including the bit sampled on that edge.
- READ: bytes are emitted little-endian, each LSB first. A 32-bit word at address A therefore appears as word bit 0..31.
  - After 8 bits the address increments.
  - The address wraps modulo 2^ADDR_BITS (0x3FF -> 0x000 at the default ADDR_BITS).
- WRITE: collect spi_mosi LSB first into a byte.
  - On the 8th bit, write the byte to the current address and increment the address with the same wrap.
- IGNORE: spi_miso=0 and nothing is written until deselect.
- Any rising edge with spi_select=1 returns to IDLE, clears the bit counter and forces spi_miso=0. A partially collected write byte is discarded.
- Backdoor load: when load_en=1, mem[load_addr] <= load_data on that edge. This is accepted in any state. If it hits the same address as an SPI write commit on the same edge, the load wins.

## Timing
- Reset values: spi_miso=0, state IDLE, bit counter 0, address 0.
- Assertion of rstn mid-transfer aborts immediately, with no partial write. After release, the device waits for select to be high for at least one edge before a new transaction decodes.
- Select-low edges are numbered from 1.
  - Edges 1..8 carry the command.
  - Edges 9..32 carry the address.
- READ latency:
  - On edge 32, spi_miso <= mem[A][0].
  - On edge 32+k, spi_miso <= bit k of the stream.
  - The host samples stream bit k on edge 33+k, which gives zero dummy cycles.
  - This requires a combinational read address built from the address shift register plus the current mosi bit at edge 32.
- WRITE: data bit j is sampled on edge 33+j. Byte n commits on edge 40+8n and is readable by a READ issued afterwards.
- spi_miso only changes on rising clk edges. It is 0 outside READ.

## Test plan
- Backdoor load of 0x93,0x00,0x10,0x00 at addresses 4..7, then READ 0x03 with addr 0x000004 and 32 data cycles -> captured word 0x00100093, first bit sampled 1 on edge 33.
- WRITE 0x02 to addr 0x000100 with bytes 0xA5,0x3C, deselect, then READ the same address -> 16 bits return 0xA5, 0x3C, LSB first.
- READ at address 0x3FF for 16 bits with ADDR_BITS=10 -> mem[0x3FF] followed by mem[0x000]; address bits 23:10 set to 1s do not change the result.
- Unknown command 0x9F, then 40 cycles -> spi_miso stays 0 and memory is unchanged; the next valid READ works.
- Deselect after 5 bits of a WRITE byte, and separately assert rstn low mid-READ -> no byte written, spi_miso=0 immediately, next transaction decodes correctly.
- SPI write commit and load_en to the same address on the same edge -> the load_data value is read back.
